// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble (shift-add-3) binary-to-BCD converter.
// Converts a WIDTH-bit value into DIGITS packed BCD digits. One shift happens per clock.
// Each conversion takes WIDTH+2 cycles: the accept edge, WIDTH shifts, and one DONE cycle.
// Optional macro SIGNED_MODE_EN: bin_in is treated as two's complement.
// The magnitude is converted and the sign is reported on neg.
// Without the macro, bin_in is unsigned and neg is tied to 0.
//
// Handshake: start is sampled only while ready=1 (IDLE). bin_in is captured on that accepting edge.
// start and bin_in are ignored while busy=1.
// done is a one-cycle pulse, and bcd_out/neg carry a fresh result during that cycle.
// bcd_out/neg then hold that result until the next done pulse.
module bcd_seq_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                neg,
    output logic [1:0]          dbg_state
);

    localparam int SW = 4*DIGITS + WIDTH;   // scratch width: BCD field above the binary field
    localparam int BW = 4*DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Elaboration-time check: the digit count must hold the largest input value.
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
        $error("bcd_seq_converter: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [WIDTH-1:0] operand;
    logic [SW-1:0]   corrected;
    logic [SW-1:0]   shifted;

`ifdef SIGNED_MODE_EN
    logic            sign_q, sign_d;
    logic            neg_q, neg_d;

    // The magnitude of the two's complement input is computed as WIDTH-bit unsigned.
    // The most-negative value maps to 2**(WIDTH-1), which still fits.
    always_comb begin
        operand = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
    end
`else
    // In the unsigned build, the operand is the raw input.
    always_comb begin
        operand = bin_in;
    end
`endif

    // Apply add-3 to every BCD nibble that is >= 5, all in parallel, then shift the whole scratch left.
    always_comb begin
        corrected = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[WIDTH + 4*i +: 4] >= 4'd5) begin
                corrected[WIDTH + 4*i +: 4] = scratch_q[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        shifted = {corrected[SW-2:0], 1'b0};
    end

    // FSM next-state logic and datapath loads.
    // bcd_out only changes when the last shift lands, so partial values are never visible.
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
`ifdef SIGNED_MODE_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SHIFT;
                    scratch_d = {{BW{1'b0}}, operand};
                    count_d   = CW'(WIDTH);
`ifdef SIGNED_MODE_EN
                    sign_d    = bin_in[WIDTH-1];
`endif
                end
            end
            S_SHIFT: begin
                scratch_d = shifted;
                count_d   = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = shifted[SW-1 -: BW];
`ifdef SIGNED_MODE_EN
                    neg_d   = sign_q;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. A synchronous reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
`ifdef SIGNED_MODE_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
`ifdef SIGNED_MODE_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign busy      = ~ready;
    assign done      = (state_q == S_DONE);
    assign bcd_out   = bcd_q;
    assign dbg_state = state_q;
`ifdef SIGNED_MODE_EN
    assign neg       = neg_q;
`else
    assign neg       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: directed table, hand-written corner sequences and a full sweep
// for bcd_seq_converter.
// Expected results come from a digit-by-digit div/mod reference model.
module tb_bcd_seq_converter;

    localparam int WIDTH = 8;
    localparam int DIGITS = 3;
    localparam int BW = 4*DIGITS;
    localparam int LAT = WIDTH;
    localparam int BOUND = 40;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [BW-1:0]    bcd_out;
    logic             neg;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_in    (bin_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .neg       (neg),
        .dbg_state (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [BW-1:0] exp_q[$];
    logic          exp_neg_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits of the magnitude using plain arithmetic.
    function automatic logic [BW-1:0] model_bcd(input logic [WIDTH-1:0] v);
        int m;
        m = int'(v);
`ifdef SIGNED_MODE_EN
        if (v[WIDTH-1]) m = (1 << WIDTH) - int'(v);
`endif
        return {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic model_neg(input logic [WIDTH-1:0] v);
`ifdef SIGNED_MODE_EN
        return v[WIDTH-1];
`else
        return 1'b0 & v[0];
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done and reports the cycle count from the accept edge.
    // It also checks that bcd_out never moves before done.
    task automatic wait_done(input string name, input logic [BW-1:0] hold_val, output int lat);
        logic stable;
        stable = 1'b1;
        lat = 0;
        while (done !== 1'b1 && lat < BOUND) begin
            if (bcd_out !== hold_val) stable = 1'b0;
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(LAT));
        check({name, " hold"}, {31'd0, stable}, 32'd1);
    endtask

    // Runs one conversion from IDLE and compares the result against the scoreboard head.
    task automatic run_conv(input string name, input logic [WIDTH-1:0] v);
        logic [BW-1:0] hold_val;
        logic [BW-1:0] e_bcd;
        logic          e_neg;
        int            lat;
        hold_val = bcd_out;
        start  = 1'b1;
        bin_in = v;
        tick();                               // accept edge E0
        start  = 1'b0;
        bin_in = WIDTH'($urandom);            // must not affect the running conversion
        check({name, " ready_low"}, {31'd0, ready}, 32'd0);
        wait_done(name, hold_val, lat);
        e_bcd = exp_q.pop_front();
        e_neg = exp_neg_q.pop_front();
        check({name, " bcd"}, 32'(bcd_out), 32'(e_bcd));
        check({name, " neg"}, {31'd0, neg}, {31'd0, e_neg});
        tick();                               // DONE -> IDLE
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
        check({name, " ready_back"}, {31'd0, ready}, 32'd1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] bin;
        logic [BW-1:0]    bcd;
        logic             neg;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int            lat;
        logic          saw_done;
        logic [BW-1:0] hold_val;

        // Directed table
`ifdef SIGNED_MODE_EN
        tbl[0] = '{8'd0,   12'h000, 1'b0};
        tbl[1] = '{8'd100, 12'h100, 1'b0};
        tbl[2] = '{8'd9,   12'h009, 1'b0};
        tbl[3] = '{8'h80,  12'h128, 1'b1};
        tbl[4] = '{8'hFF,  12'h001, 1'b1};
        tbl[5] = '{8'h7F,  12'h127, 1'b0};
        tbl[6] = '{8'd15,  12'h015, 1'b0};
        tbl[7] = '{8'hF6,  12'h010, 1'b1};
`else
        tbl[0] = '{8'd255, 12'h255, 1'b0};
        tbl[1] = '{8'd0,   12'h000, 1'b0};
        tbl[2] = '{8'd100, 12'h100, 1'b0};
        tbl[3] = '{8'd9,   12'h009, 1'b0};
        tbl[4] = '{8'h80,  12'h128, 1'b0};
        tbl[5] = '{8'h7F,  12'h127, 1'b0};
        tbl[6] = '{8'd199, 12'h199, 1'b0};
        tbl[7] = '{8'd250, 12'h250, 1'b0};
`endif

        // Reset state
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        check("reset ready", {31'd0, ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset bcd", 32'(bcd_out), 32'd0);
        check("reset neg", {31'd0, neg}, 32'd0);
        check("reset state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        tick();

        // Apply the directed table
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbl[i].bcd);
            exp_neg_q.push_back(tbl[i].neg);
            run_conv($sformatf("tbl%0d", i), tbl[i].bin);
        end

        // start held through busy with a changing bin_in. The second accept must occur
        // at the first IDLE edge.
        start  = 1'b1;
        bin_in = 8'd42;
        tick();                                   // accept 42
        bin_in = 8'd77;
        check("hold start busy", {31'd0, busy}, 32'd1);
        wait_done("hold first", bcd_out, lat);
        check("hold first bcd", 32'(bcd_out), 32'h042);
        hold_val = bcd_out;
        tick();                                   // DONE -> IDLE, start ignored here
        check("hold idle ready", {31'd0, ready}, 32'd1);
        tick();                                   // accept 77
        check("hold second accepted", {31'd0, ready}, 32'd0);
        start = 1'b0;
        wait_done("hold second", hold_val, lat);
        check("hold second bcd", 32'(bcd_out), 32'(model_bcd(8'd77)));
        tick();

        // Reset mid-conversion aborts without a done pulse
        start  = 1'b1;
        bin_in = 8'd200;
        tick();                                   // accept 200
        start  = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort bcd zero", 32'(bcd_out), 32'd0);
        check("abort ready", {31'd0, ready}, 32'd1);
        check("abort neg", {31'd0, neg}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("abort no done", {31'd0, saw_done}, 32'd0);
        exp_q.push_back(12'h015);
        exp_neg_q.push_back(1'b0);
        run_conv("after abort", 8'd15);

        // Full sweep against the model
        for (int v = 0; v < (1 << WIDTH); v++) begin
            exp_q.push_back(model_bcd(WIDTH'(v)));
            exp_neg_q.push_back(model_neg(WIDTH'(v)));
            run_conv($sformatf("sweep%0d", v), WIDTH'(v));
        end

        // Random values with random idle gaps
        for (int k = 0; k < 40; k++) begin
            logic [WIDTH-1:0] r;
            r = WIDTH'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            exp_q.push_back(model_bcd(r));
            exp_neg_q.push_back(model_neg(r));
            run_conv($sformatf("rand%0d", k), r);
        end

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
